// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
// Bus widths of the latched request are fixed here; the top's ADDR_W/DATA_W must not exceed them.
package mem_bus_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W = 64;
   localparam int unsigned MEM_DATA_W = 64;
   localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;
   localparam int unsigned STREAK_W   = 4;

   // Access size used for every instruction fetch (4 bytes).
   localparam logic [2:0] MSIZE4 = 3'd2;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

   typedef struct packed {
      logic                  valid;
      logic                  write;
      logic [MEM_ADDR_W-1:0] addr;
      logic [2:0]            size;
      logic [MEM_STRB_W-1:0] strobe;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner selection: dbus has priority unless ibus has been
// starved for MAX_D_STREAK consecutive dbus grants.
module arb_pick
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                i_valid,
   input  logic                d_valid,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_i_c,
   output logic                grant_d_c
);

   logic force_i;

   // Winner decode; exactly one grant when any requester is valid.
   always_comb begin
      force_i   = i_valid && (streak == STREAK_W'(MAX_D_STREAK));
      grant_d_c = d_valid && !force_i;
      grant_i_c = i_valid && !grant_d_c;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single memory port between the fetch bus and the data bus,
// one transaction at a time, returning each response to its issuer.
// Optional macro ARB_PERF_CNT_EN adds grant and busy-cycle counters.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_addr_ok,
   output logic                i_data_ok,
   output logic [31:0]         i_rdata,
   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [2:0]          d_size,
   input  logic [DATA_W/8-1:0] d_strobe,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_addr_ok,
   output logic                d_data_ok,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_valid,
   output logic                m_write,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [2:0]          m_size,
   output logic [DATA_W/8-1:0] m_strobe,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_ready,
   input  logic [DATA_W-1:0]   m_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_i_grants,
   output logic [31:0]         perf_d_grants,
   output logic [31:0]         perf_busy_cycles
`endif
);

   arb_state_t          state_q, state_d;
   arb_owner_t          owner_q;
   logic [STREAK_W-1:0] streak_q;
   mem_req_t            m_q;
   logic                grant_i_c, grant_d_c;
   logic                done_c;

   assign done_c = (state_q == REQ) && m_ready;

   arb_pick #(
      .MAX_D_STREAK (MAX_D_STREAK)
   ) u_pick (
      .i_valid   (i_valid),
      .d_valid   (d_valid),
      .streak    (streak_q),
      .grant_i_c (grant_i_c),
      .grant_d_c (grant_d_c)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and same-cycle accept; accepts are held off while reset is asserted.
   always_comb begin
      state_d   = state_q;
      i_addr_ok = 1'b0;
      d_addr_ok = 1'b0;
      case (state_q)
         IDLE: begin
            i_addr_ok = grant_i_c && reset;
            d_addr_ok = grant_d_c && reset;
            if (grant_i_c || grant_d_c) state_d = REQ;
         end
         REQ:     if (m_ready) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the winner's request; hold it stable until memory completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q     <= '0;
         owner_q <= OWN_I;
      end else if (d_addr_ok) begin
         m_q.valid  <= 1'b1;
         m_q.write  <= |d_strobe;
         m_q.addr   <= MEM_ADDR_W'(d_addr);
         m_q.size   <= d_size;
         m_q.strobe <= MEM_STRB_W'(d_strobe);
         m_q.wdata  <= MEM_DATA_W'(d_wdata);
         owner_q    <= OWN_D;
      end else if (i_addr_ok) begin
         m_q.valid  <= 1'b1;
         m_q.write  <= 1'b0;
         m_q.addr   <= MEM_ADDR_W'(i_addr);
         m_q.size   <= MSIZE4;
         m_q.strobe <= '0;
         m_q.wdata  <= '0;
         owner_q    <= OWN_I;
      end else if (done_c) begin
         m_q.valid  <= 1'b0;
      end
   end

   // Capture read data for the owner and pulse its data_ok for one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_data_ok <= 1'b0;
         d_data_ok <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_data_ok <= 1'b0;
         d_data_ok <= 1'b0;
         if (done_c) begin
            if (owner_q == OWN_I) begin
               i_data_ok <= 1'b1;
               i_rdata   <= m_rdata[31:0];
            end else begin
               d_data_ok <= 1'b1;
               d_rdata   <= m_rdata;
            end
         end
      end
   end

   // Count consecutive dbus grants taken while ibus was waiting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak_q <= '0;
      end else if (i_addr_ok) begin
         streak_q <= '0;
      end else if (d_addr_ok) begin
         if (!i_valid)
            streak_q <= '0;
         else if (streak_q != STREAK_W'(MAX_D_STREAK))
            streak_q <= streak_q + STREAK_W'(1);
      end
   end

   assign m_valid  = m_q.valid;
   assign m_write  = m_q.write;
   assign m_addr   = m_q.addr[ADDR_W-1:0];
   assign m_size   = m_q.size;
   assign m_strobe = m_q.strobe[DATA_W/8-1:0];
   assign m_wdata  = m_q.wdata[DATA_W-1:0];

`ifdef ARB_PERF_CNT_EN
   // Wrap-around grant and occupancy counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_i_grants    <= '0;
         perf_d_grants    <= '0;
         perf_busy_cycles <= '0;
      end else begin
         if (i_addr_ok)         perf_i_grants    <= perf_i_grants + 32'd1;
         if (d_addr_ok)         perf_d_grants    <= perf_d_grants + 32'd1;
         if (state_q != IDLE)   perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

   localparam int unsigned AW   = 64;
   localparam int unsigned DW   = 64;
   localparam int unsigned SW   = DW / 8;
   localparam int          MAXS = 4;
   localparam int          INF  = 32'h7fff_ffff;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_valid, i_addr_ok, i_data_ok;
   logic [AW-1:0] i_addr;
   logic [31:0]   i_rdata;
   logic          d_valid, d_addr_ok, d_data_ok;
   logic [AW-1:0] d_addr;
   logic [2:0]    d_size;
   logic [SW-1:0] d_strobe;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          m_valid, m_write, m_ready;
   logic [AW-1:0] m_addr;
   logic [2:0]    m_size;
   logic [SW-1:0] m_strobe;
   logic [DW-1:0] m_wdata, m_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_i_grants, perf_d_grants, perf_busy_cycles;
`endif

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .MAX_D_STREAK (MAXS)
   ) dut (
      .clk (clk), .reset (reset),
      .i_valid (i_valid), .i_addr (i_addr), .i_addr_ok (i_addr_ok),
      .i_data_ok (i_data_ok), .i_rdata (i_rdata),
      .d_valid (d_valid), .d_addr (d_addr), .d_size (d_size),
      .d_strobe (d_strobe), .d_wdata (d_wdata), .d_addr_ok (d_addr_ok),
      .d_data_ok (d_data_ok), .d_rdata (d_rdata),
      .m_valid (m_valid), .m_write (m_write), .m_addr (m_addr),
      .m_size (m_size), .m_strobe (m_strobe), .m_wdata (m_wdata),
      .m_ready (m_ready), .m_rdata (m_rdata)
`ifdef ARB_PERF_CNT_EN
      , .perf_i_grants (perf_i_grants), .perf_d_grants (perf_d_grants),
      .perf_busy_cycles (perf_busy_cycles)
`endif
   );

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [2:0]    size;
      logic [SW-1:0] strobe;
      logic [DW-1:0] wdata;
      int            due;
   } mreq_exp_t;

   typedef struct {
      bit            own_d;
      logic [DW-1:0] data;
      int            due;
   } resp_exp_t;

   mreq_exp_t mreq_q[$];
   resp_exp_t resp_q[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // requester / memory stimulus state
   bit i_pend, i_acc, i_drop, d_pend, d_acc, d_drop;
   bit gen, drop_en, mem_stall, mem_done;
   int p_i, p_d, maxlat, mem_wait;

   // reference model: port free from cycle free_at, ibus starvation streak
   int free_at, streak, g_cyc, n_i, n_d, n_busy;
   bit m_own_d;

   // monitor state
   bit        mon_en, prev_mv;
   mreq_exp_t cur;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bad(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
   endtask

   task automatic clear_model();
      mreq_q.delete();
      resp_q.delete();
      free_at = 0; streak = 0; g_cyc = 0; m_own_d = 0;
      n_i = 0; n_d = 0; n_busy = 0;
      i_pend = 0; i_acc = 0; i_drop = 0;
      d_pend = 0; d_acc = 0; d_drop = 0;
      mem_wait = -1; mem_done = 0; prev_mv = 0;
   endtask

   // One cycle: drive requesters and memory at negedge, then check accepts against the model.
   task automatic step();
      bit        win_i, win_d;
      mreq_exp_t e;
      resp_exp_t r;
      @(negedge clk);
      if (i_data_ok) i_pend = 1'b0;
      if (d_data_ok) d_pend = 1'b0;
      if (gen && !i_pend && ($urandom_range(99) < p_i)) begin
         i_pend = 1; i_acc = 0; i_drop = 0;
         i_addr = {$urandom, $urandom};
      end
      if (gen && !d_pend && ($urandom_range(99) < p_d)) begin
         d_pend = 1; d_acc = 0; d_drop = 0;
         d_addr   = {$urandom, $urandom};
         d_size   = 3'($urandom_range(3));
         d_strobe = ($urandom_range(1) == 0) ? '0 : SW'($urandom);
         d_wdata  = {$urandom, $urandom};
      end
      if (i_acc && drop_en && ($urandom_range(2) == 0)) i_drop = 1;
      if (d_acc && drop_en && ($urandom_range(2) == 0)) d_drop = 1;
      i_valid = i_pend && !i_drop;
      d_valid = d_pend && !d_drop;

      m_ready = 1'b0;
      m_rdata = {$urandom, $urandom};
      if (!m_valid) begin
         mem_done = 0;
      end else if (!mem_done && !mem_stall) begin
         if (mem_wait < 0) mem_wait = $urandom_range(maxlat);
         if (mem_wait == 0) begin
            m_ready  = 1'b1;
            mem_done = 1;
            mem_wait = -1;
            r.own_d = m_own_d;
            r.data  = m_own_d ? m_rdata : {32'd0, m_rdata[31:0]};
            r.due   = cyc + 1;
            resp_q.push_back(r);
            free_at = cyc + 2;
            n_busy += cyc - g_cyc + 1;
         end else begin
            mem_wait--;
         end
      end

      #1;
      win_i = 0;
      win_d = 0;
      if (cyc >= free_at) begin
         if (d_valid && !(i_valid && streak == MAXS)) win_d = 1;
         else if (i_valid) win_i = 1;
      end
      chk("i_addr_ok", i_addr_ok, win_i);
      chk("d_addr_ok", d_addr_ok, win_d);
      if (win_d) begin
         streak   = i_valid ? ((streak < MAXS) ? streak + 1 : streak) : 0;
         e.write  = |d_strobe;
         e.addr   = d_addr;
         e.size   = d_size;
         e.strobe = d_strobe;
         e.wdata  = d_wdata;
         e.due    = cyc + 1;
         mreq_q.push_back(e);
         m_own_d = 1; free_at = INF; g_cyc = cyc; n_d++;
      end else if (win_i) begin
         streak   = 0;
         e.write  = 1'b0;
         e.addr   = i_addr;
         e.size   = 3'd2;
         e.strobe = '0;
         e.wdata  = '0;
         e.due    = cyc + 1;
         mreq_q.push_back(e);
         m_own_d = 0; free_at = INF; g_cyc = cyc; n_i++;
      end
      if (i_addr_ok) i_acc = 1;
      if (d_addr_ok) d_acc = 1;
   endtask

   // Monitor: match memory requests and responses against the scoreboard queues.
   always @(posedge clk) begin
      resp_exp_t r;
      #1;
      if (mon_en) begin
         if (mreq_q.size() > 0 && mreq_q[0].due < cyc) begin
            bad("m_req_missing");
            void'(mreq_q.pop_front());
         end
         if (m_valid && !prev_mv) begin
            if (mreq_q.size() == 0) begin
               bad("m_req_unexpected");
            end else begin
               cur = mreq_q.pop_front();
               chk("m_start_cycle", cyc, cur.due);
            end
         end
         if (m_valid) begin
            chk("m_write", m_write, cur.write);
            chk("m_addr", m_addr, cur.addr);
            chk("m_size", m_size, cur.size);
            chk("m_strobe", m_strobe, cur.strobe);
            chk("m_wdata", m_wdata, cur.wdata);
         end
         if (resp_q.size() > 0 && resp_q[0].due < cyc) begin
            bad("data_ok_missing");
            void'(resp_q.pop_front());
         end
         if (i_data_ok && d_data_ok) bad("both_data_ok");
         if (i_data_ok || d_data_ok) begin
            if (resp_q.size() == 0) begin
               bad("data_ok_unexpected");
            end else begin
               r = resp_q.pop_front();
               chk("resp_owner_d", d_data_ok, r.own_d);
               chk("resp_cycle", cyc, r.due);
               chk("resp_rdata", d_data_ok ? d_rdata : {32'd0, i_rdata}, r.data);
            end
         end
         prev_mv = m_valid;
      end
   end

   // Stall memory, reset while a request is outstanding, then run a fetch.
   task automatic reset_in_req();
      bit seen = 0;
      mem_stall = 1;
      for (int n = 0; n < 40 && !seen; n++) begin
         step();
         if (m_valid) seen = 1;
      end
      if (!seen) bad("reset_req_timeout");
      mon_en  = 0;
      reset   = 1'b0;
      i_valid = 1'b0;
      d_valid = 1'b0;
      m_ready = 1'b0;
      #1;
      chk("rst_async_m_valid", m_valid, 1'b0);
      chk("rst_async_i_data_ok", i_data_ok, 1'b0);
      chk("rst_async_d_data_ok", d_data_ok, 1'b0);
      chk("rst_async_d_rdata", d_rdata, 64'd0);
      chk("rst_async_i_rdata", i_rdata, 64'd0);
      chk("rst_async_m_addr", m_addr, 64'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_m_valid", m_valid, 1'b0);
      chk("rst_hold_data_ok", {i_data_ok, d_data_ok}, 2'b00);
      clear_model();
      @(negedge clk);
      reset     = 1'b1;
      mem_stall = 0;
      mon_en    = 1;
      gen       = 0;
      i_pend    = 1;
      i_addr    = 64'h0000_0000_8000_0000;
      repeat (8) step();
      chk("fetch_after_reset_done", i_pend, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      i_valid = 0; i_addr = '0;
      d_valid = 0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
      m_ready = 0; m_rdata = '0;
      clear_model();
      gen = 0; drop_en = 0; mem_stall = 0; mon_en = 0;
      p_i = 0; p_d = 0; maxlat = 0;

      repeat (3) @(negedge clk);
      i_valid = 1'b1;
      d_valid = 1'b1;
      #1;
      chk("rst_i_addr_ok", i_addr_ok, 1'b0);
      chk("rst_d_addr_ok", d_addr_ok, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_write", m_write, 1'b0);
      chk("rst_m_strobe", m_strobe, '0);
      chk("rst_data_ok", {i_data_ok, d_data_ok}, 2'b00);
      chk("rst_i_rdata", i_rdata, 64'd0);
      chk("rst_d_rdata", d_rdata, 64'd0);
      i_valid = 1'b0;
      d_valid = 1'b0;
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1;

      gen = 1; p_i = 30; p_d = 30; maxlat = 3;
      repeat (400) step();
      p_i = 100; p_d = 100; maxlat = 0;
      repeat (200) step();
      drop_en = 1; p_i = 50; p_d = 60; maxlat = 6;
      repeat (300) step();
      drop_en = 0;
      reset_in_req();
      gen = 1; p_i = 40; p_d = 40; maxlat = 2;
      repeat (300) step();
      gen = 0;
      repeat (40) step();

      chk("end_mreq_q_empty", mreq_q.size(), 0);
      chk("end_resp_q_empty", resp_q.size(), 0);
      chk("end_i_idle", i_pend, 1'b0);
      chk("end_d_idle", d_pend, 1'b0);
`ifdef ARB_PERF_CNT_EN
      chk("perf_i_grants", perf_i_grants, n_i);
      chk("perf_d_grants", perf_d_grants, n_d);
      chk("perf_busy_cycles", perf_busy_cycles, n_busy);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
